// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the registered priority encoder.
// Imported by the search core and the pipelined top.
package prio_enc_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Widest request vector the helpers are sized for
  localparam int MAX_N = 256;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Clearing the lowest set bit leaves something iff two or more were set
  function automatic logic is_multi(
    input logic [MAX_N-1:0] vec
  );
    return |(vec & (vec - MAX_N'(1)));
  endfunction

endpackage

// File: rtl/prio_search_comb.sv
// Combinational circular search: first set bit at or after start,
// walking upward (or downward when DESCEND) and wrapping mod N.
module prio_search_comb
  import prio_enc_pkg::*;
#(
  parameter int N       = 8,
  parameter int W       = clog2_min1(N),
  parameter bit DESCEND = 1'b0
) (
  input  logic [W-1:0] start,
  input  logic [N-1:0] vec,
  output logic         found,
  output logic [W-1:0] idx
);

  always_comb begin
    int p;
    found = 1'b0;
    idx   = '0;
    p     = 0;
    // Walk farthest-first so the nearest hit is written last
    for (int k = N - 1; k >= 0; k--) begin
      p = DESCEND ? int'(start) - k
                  : int'(start) + k;
      if (p < 0) begin
        p = p + N;
      end else if (p >= N) begin
        p = p - N;
      end
      if (vec[W'(p)]) begin
        found = 1'b1;
        idx   = W'(p);
      end
    end
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-to-W priority encoder, fixed or round-robin,
// with zero/multi flags and a one-stage valid/ready output.
module prio_encoder_rr
  import prio_enc_pkg::*;
#(
  parameter int N       = 8,
  parameter int W       = clog2_min1(N),
  parameter int RR_MODE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         req_valid,
  output logic         req_ready,
  output logic [W-1:0] idx,
  output logic         zero,
  output logic         multi,
  output logic         idx_valid,
  input  logic         idx_ready
);

  localparam bit IS_RR = (RR_MODE == MODE_RR);
  localparam bit DESC  = (RR_MODE == MODE_FIXED);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] rr_ptr;
  logic [W-1:0] start;
  logic [W-1:0] hit;
  logic         found;
  logic         capture;

  assign req_ready = !idx_valid || idx_ready;
  assign capture   = req_valid && req_ready;

  // Fixed mode scans down from the top line; RR resumes after last winner
  always_comb begin
    start = LAST;
    if (IS_RR) begin
      start = (rr_ptr == LAST) ? '0
                               : rr_ptr + W'(1);
    end
  end

  prio_search_comb #(
    .N       (N),
    .W       (W),
    .DESCEND (DESC)
  ) u_search (
    .start (start),
    .vec   (req),
    .found (found),
    .idx   (hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      zero      <= 1'b0;
      multi     <= 1'b0;
      idx_valid <= 1'b0;
      rr_ptr    <= LAST;
    end else if (capture) begin
      idx       <= hit;
      zero      <= !found;
      multi     <= is_multi(MAX_N'(req));
      idx_valid <= 1'b1;
      if (IS_RR && found) begin
        rr_ptr <= hit;
      end
    end else if (idx_ready) begin
      idx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench: four encoder configurations on shared handshake lines,
// checked every cycle against a behavioural model plus literal cases.
module tb_prio_encoder_rr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0;
  logic       idx_ready = 1'b0;
  logic [7:0] req = '0;

  int checks = 0;
  int errors = 0;

  localparam int NS[4] = '{8, 8, 5, 4};
  localparam int MD[4] = '{0, 1, 1, 0};

  logic [2:0] idx0, idx1, idx2;
  logic [1:0] idx3;
  logic [3:0] rdy, zr, ml, vl;
  logic [2:0] didx[4];

  assign didx[0] = idx0;
  assign didx[1] = idx1;
  assign didx[2] = idx2;
  assign didx[3] = {1'b0, idx3};

  always #5 clk = ~clk;

  prio_encoder_rr #(.N(8), .RR_MODE(0)) u_fix8 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .req_valid(req_valid), .req_ready(rdy[0]),
    .idx(idx0), .zero(zr[0]), .multi(ml[0]),
    .idx_valid(vl[0]), .idx_ready(idx_ready));

  prio_encoder_rr #(.N(8), .RR_MODE(1)) u_rr8 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .req_valid(req_valid), .req_ready(rdy[1]),
    .idx(idx1), .zero(zr[1]), .multi(ml[1]),
    .idx_valid(vl[1]), .idx_ready(idx_ready));

  prio_encoder_rr #(.N(5), .RR_MODE(1)) u_rr5 (
    .clk(clk), .rst_n(rst_n), .req(req[4:0]),
    .req_valid(req_valid), .req_ready(rdy[2]),
    .idx(idx2), .zero(zr[2]), .multi(ml[2]),
    .idx_valid(vl[2]), .idx_ready(idx_ready));

  prio_encoder_rr #(.N(4), .RR_MODE(0)) u_fix4 (
    .clk(clk), .rst_n(rst_n), .req(req[3:0]),
    .req_valid(req_valid), .req_ready(rdy[3]),
    .idx(idx3), .zero(zr[3]), .multi(ml[3]),
    .idx_valid(vl[3]), .idx_ready(idx_ready));

  // Reference: popcount, highest set bit, or (ptr+k) mod n scan
  function automatic void model_eval(
    input  int         n,
    input  int         mode,
    input  int         ptr,
    input  logic [7:0] r,
    output int         ix,
    output bit         z,
    output bit         m,
    output int         np
  );
    int cnt;
    cnt = 0;
    ix  = 0;
    np  = ptr;
    for (int j = 0; j < n; j++)
      if (r[j[2:0]]) cnt++;
    z = (cnt == 0);
    m = (cnt >= 2);
    if (cnt == 0) return;
    if (mode == 0) begin
      for (int j = 0; j < n; j++)
        if (r[j[2:0]]) ix = j;
    end else begin
      for (int k = n; k >= 1; k--) begin
        int j;
        j = (ptr + k) % n;
        if (r[j[2:0]]) ix = j;
      end
      np = ix;
    end
  endfunction

  bit mv[4];
  bit mz[4];
  bit mm[4];
  int mi[4];
  int mp[4];

  always @(posedge clk or negedge rst_n) begin
    int ni, np;
    bit nz, nm;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        mv[i] <= 1'b0;
        mi[i] <= 0;
        mz[i] <= 1'b0;
        mm[i] <= 1'b0;
        mp[i] <= NS[i] - 1;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (req_valid && (!mv[i] || idx_ready)) begin
          model_eval(NS[i], MD[i], mp[i], req,
                     ni, nz, nm, np);
          mv[i] <= 1'b1;
          mi[i] <= ni;
          mz[i] <= nz;
          mm[i] <= nm;
          mp[i] <= np;
        end else if (idx_ready) begin
          mv[i] <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d t=%0t",
               nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("m%0d_valid", i), 32'(vl[i]), 32'(mv[i]));
        chk($sformatf("m%0d_ready", i), 32'(rdy[i]),
            32'(!mv[i] || idx_ready));
        if (mv[i]) begin
          chk($sformatf("m%0d_idx", i), 32'(didx[i]), mi[i]);
          chk($sformatf("m%0d_zero", i), 32'(zr[i]), 32'(mz[i]));
          chk($sformatf("m%0d_multi", i), 32'(ml[i]), 32'(mm[i]));
        end
      end
    end
  end

  task automatic lit(input string nm, input int i,
                     input int ix, input bit z, input bit m);
    chk({nm, "_valid"}, 32'(vl[i]), 1);
    chk({nm, "_idx"}, 32'(didx[i]), ix);
    chk({nm, "_zero"}, 32'(zr[i]), 32'(z));
    chk({nm, "_multi"}, 32'(ml[i]), 32'(m));
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int e3[4];
    int e6[4];
    e3 = '{0, 2, 7, 0};
    e6 = '{0, 4, 0, 4};

    #1 rst_n = 1'b0;
    #2;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst%0d_valid", i), 32'(vl[i]), 0);
      chk($sformatf("rst%0d_idx", i), 32'(didx[i]), 0);
      chk($sformatf("rst%0d_zero", i), 32'(zr[i]), 0);
      chk($sformatf("rst%0d_multi", i), 32'(ml[i]), 0);
    end
    tick();
    rst_n = 1'b1;

    // One-hot walk on N=4, back-to-back, both modes agree
    req_valid = 1'b1;
    idx_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      req = 8'(1 << b);
      tick();
      lit("t1_fix4", 3, b, 1'b0, 1'b0);
      lit("t1_rr8", 1, b, 1'b0, 1'b0);
    end

    do_reset();
    req = 8'hA6;
    tick();
    lit("t2_multi", 0, 7, 1'b0, 1'b1);
    req = 8'h00;
    tick();
    lit("t2_zero", 0, 0, 1'b1, 1'b0);

    do_reset();
    req = 8'h85;
    for (int k = 0; k < 4; k++) begin
      tick();
      lit($sformatf("t3_rr%0d", k), 1, e3[k], 1'b0, 1'b1);
    end

    do_reset();
    req = 8'h20;
    tick();
    lit("t4_first", 0, 5, 1'b0, 1'b0);
    idx_ready = 1'b0;
    repeat (3) begin
      req = 8'($urandom);
      tick();
      lit("t4_hold", 0, 5, 1'b0, 1'b0);
      chk("t4_ready", 32'(rdy[0]), 0);
    end
    req = 8'h03;
    idx_ready = 1'b1;
    tick();
    lit("t4_next", 0, 1, 1'b0, 1'b1);

    // Async reset landing between edges while a result is held
    idx_ready = 1'b0;
    req = 8'hFF;
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("t5_valid0", 32'(vl[0]), 0);
    chk("t5_idx0", 32'(didx[0]), 0);
    chk("t5_valid1", 32'(vl[1]), 0);
    rst_n = 1'b1;
    idx_ready = 1'b1;
    tick();
    lit("t5_rr", 1, 0, 1'b0, 1'b1);
    lit("t5_fix", 0, 7, 1'b0, 1'b1);

    do_reset();
    req = 8'hF1;
    for (int k = 0; k < 4; k++) begin
      tick();
      lit($sformatf("t6_n5_%0d", k), 2, e6[k], 1'b0, 1'b1);
    end

    repeat (3000) begin
      req       = 8'($urandom);
      if ($urandom_range(0, 3) == 0) req = 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) req = 8'h00;
      req_valid = ($urandom_range(0, 3) != 0);
      idx_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
